// File: rtl/qos_wr_arbiter.sv
// qos_wr_arbiter
// Write-side ingress arbiter in front of the QoS FIFO wrapper. It merges NREQ
// valid/ready requestors into one registered write stream. Winner selection
// ranks HiBW class first, then aged requestors, then QoS level. Ties go
// round-robin. A short gap follows every issue so that the wrapper's
// registered full flag can catch up.
module qos_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 32,
    parameter int IDW       = 2,
    parameter int AGE_W     = 4,
    parameter int AGE_LIMIT = 12,
    parameter int ISSUE_GAP = 1
) (
    input  logic                    iWrClk,
    input  logic                    iWrResetn,
    input  logic [NREQ-1:0]         iReqValid,
    input  logic [NREQ*DSIZE-1:0]   iReqData,
    input  logic [NREQ*4-1:0]       iReqQoS,
    output logic [NREQ-1:0]         oReqReady,
    input  logic                    iFull,
    output logic                    oWr,
    output logic [DSIZE-1:0]        oWrData,
    output logic [3:0]              oQoS,
    output logic [IDW-1:0]          oGrantId,
    output logic                    oAged
);

    localparam int               GAP_W    = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(AGE_LIMIT);
    localparam logic [3:0]       AGED_QOS = 4'b0110;

    typedef enum logic {
        ST_ARB,
        ST_GAP
    } state_t;

    state_t                      state_q, state_d;
    logic [GAP_W-1:0]            gap_cnt_q, gap_cnt_d;
    logic [IDW-1:0]              rr_q, rr_d;
    logic [NREQ-1:0][AGE_W-1:0]  age_q, age_d;
    logic                        wr_q, wr_d;
    logic [DSIZE-1:0]            wr_data_q, wr_data_d;
    logic [3:0]                  qos_q, qos_d;
    logic [IDW-1:0]              grant_q, grant_d;
    logic                        aged_q, aged_d;

    logic [NREQ-1:0][3:0]        req_qos;
    logic [NREQ-1:0]             req_aged;
    logic [NREQ-1:0][4:0]        req_key;
    logic [4:0]                  max_key;
    logic [NREQ-1:0]             cand;
    logic [IDW-1:0]              win_id;
    logic                        eligible;
    logic [DSIZE-1:0]            win_data;
    logic [3:0]                  win_qos;
    logic                        win_promoted;

    // Round-robin search over the candidate mask, starting at the pointer
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] mask,
                                               input logic [IDW-1:0]  ptr);
        logic [IDW-1:0] pick;
        logic           found;
        int             idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && mask[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
        return pick;
    endfunction

    // Build each requestor's priority key: {HiBW, aged, QoS level}
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_qos[i]  = iReqQoS[i*4 +: 4];
            req_aged[i] = (age_q[i] == AGE_MAX);
            req_key[i]  = {req_qos[i][3], req_aged[i], req_qos[i][2:0]};
        end
    end

    // Find the best key among valid requestors and pick round-robin within it
    always_comb begin
        max_key = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (iReqValid[i] && (req_key[i] > max_key)) begin
                max_key = req_key[i];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            cand[i] = iReqValid[i] && (req_key[i] == max_key);
        end
        win_id = rr_pick(cand, rr_q);
    end

    // Accept decision and the winner's payload; reset forces no accept
    always_comb begin
        eligible     = iWrResetn && (state_q == ST_ARB) && !iFull && (|iReqValid);
        win_data     = iReqData[int'(win_id)*DSIZE +: DSIZE];
        win_promoted = req_aged[win_id] && !req_qos[win_id][3];
        win_qos      = win_promoted ? AGED_QOS : req_qos[win_id];
        for (int i = 0; i < NREQ; i++) begin
            oReqReady[i] = eligible && (win_id == IDW'(i));
        end
    end

    // Next-state for the FSM, output registers, RR pointer and age counters
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        rr_d      = rr_q;
        wr_d      = 1'b0;
        wr_data_d = wr_data_q;
        qos_d     = qos_q;
        grant_d   = grant_q;
        aged_d    = aged_q;
        age_d     = age_q;

        case (state_q)
            ST_ARB: begin
                if (eligible) begin
                    wr_d      = 1'b1;
                    wr_data_d = win_data;
                    qos_d     = win_qos;
                    grant_d   = win_id;
                    aged_d    = win_promoted;
                    rr_d      = (win_id == IDW'(NREQ-1)) ? '0 : (win_id + IDW'(1));
                    if (ISSUE_GAP > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_W'(ISSUE_GAP - 1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_ARB;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase

        for (int i = 0; i < NREQ; i++) begin
            if (!iReqValid[i] || oReqReady[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] != AGE_MAX) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge iWrClk or negedge iWrResetn) begin
        if (!iWrResetn) begin
            state_q   <= ST_ARB;
            gap_cnt_q <= '0;
            rr_q      <= '0;
            age_q     <= '0;
            wr_q      <= 1'b0;
            wr_data_q <= '0;
            qos_q     <= '0;
            grant_q   <= '0;
            aged_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            rr_q      <= rr_d;
            age_q     <= age_d;
            wr_q      <= wr_d;
            wr_data_q <= wr_data_d;
            qos_q     <= qos_d;
            grant_q   <= grant_d;
            aged_q    <= aged_d;
        end
    end

    assign oWr      = wr_q;
    assign oWrData  = wr_data_q;
    assign oQoS     = qos_q;
    assign oGrantId = grant_q;
    assign oAged    = aged_q;

endmodule

// File: tb/tb_qos_wr_arbiter.sv
// tb_qos_wr_arbiter
// Directed bench for qos_wr_arbiter: a vector table for single-accept
// decisions taken from a fresh reset, followed by hand-written multi-cycle
// sequences for reset, ordering, round-robin, aging, full and HiBW cases.
module tb_qos_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DSIZE     = 32;
    localparam int IDW       = 2;
    localparam int AGE_W     = 4;
    localparam int AGE_LIMIT = 12;
    localparam int ISSUE_GAP = 1;
    localparam int NVEC      = 11;

    logic                  iWrClk = 1'b0;
    logic                  iWrResetn;
    logic [NREQ-1:0]       iReqValid = '0;
    logic [NREQ*DSIZE-1:0] iReqData = '0;
    logic [NREQ*4-1:0]     iReqQoS = '0;
    logic [NREQ-1:0]       oReqReady;
    logic                  iFull = 1'b0;
    logic                  oWr;
    logic [DSIZE-1:0]      oWrData;
    logic [3:0]            oQoS;
    logic [IDW-1:0]        oGrantId;
    logic                  oAged;

    int checks = 0;
    int errors = 0;

    logic [NREQ-1:0] keepMask = '0;
    logic [NREQ-1:0] readyCap = '0;

    int issId   [8];
    int issQos  [8];
    int issAged [8];
    int issCyc  [8];
    logic [31:0] issData [8];

    typedef struct packed {
        logic [3:0]  valid;
        logic [15:0] qos;
        logic        full;
        logic [3:0]  expReady;
        logic        expWr;
        logic [1:0]  expId;
        logic [3:0]  expQos;
        logic        expAged;
    } vec_t;

    vec_t vecs [NVEC];

    qos_wr_arbiter #(
        .NREQ(NREQ), .DSIZE(DSIZE), .IDW(IDW), .AGE_W(AGE_W),
        .AGE_LIMIT(AGE_LIMIT), .ISSUE_GAP(ISSUE_GAP)
    ) dut (
        .iWrClk    (iWrClk),
        .iWrResetn (iWrResetn),
        .iReqValid (iReqValid),
        .iReqData  (iReqData),
        .iReqQoS   (iReqQoS),
        .oReqReady (oReqReady),
        .iFull     (iFull),
        .oWr       (oWr),
        .oWrData   (oWrData),
        .oQoS      (oQoS),
        .oGrantId  (oGrantId),
        .oAged     (oAged)
    );

    always #5 iWrClk = ~iWrClk;

    function automatic logic [31:0] dataFor(input int idx, input int tag);
        return 32'hD000_0000 | (32'(idx) << 16) | 32'(tag);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic setReq(input int idx, input logic [3:0] q, input logic [31:0] d);
        iReqValid[idx]              = 1'b1;
        iReqQoS[idx*4 +: 4]         = q;
        iReqData[idx*DSIZE +: DSIZE] = d;
    endtask

    // One clock: capture ready before the edge, then retire accepted requestors
    task automatic tick();
        @(negedge iWrClk);
        readyCap = oReqReady;
        @(posedge iWrClk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (readyCap[i] && !keepMask[i]) begin
                iReqValid[i] = 1'b0;
            end
        end
    endtask

    task automatic doReset();
        iWrResetn = 1'b0;
        #2;
        iWrResetn = 1'b1;
    endtask

    task automatic clearIssues();
        for (int k = 0; k < 8; k++) begin
            issId[k]   = -1;
            issQos[k]  = -1;
            issAged[k] = -1;
            issCyc[k]  = -1;
            issData[k] = '0;
        end
    endtask

    task automatic collectIssues(input int want, input int maxCycles, output int got);
        got = 0;
        clearIssues();
        for (int c = 1; c <= maxCycles && got < want; c++) begin
            tick();
            if (oWr === 1'b1) begin
                issId[got]   = int'(oGrantId);
                issQos[got]  = int'(oQoS);
                issAged[got] = int'(oAged);
                issCyc[got]  = c;
                issData[got] = oWrData;
                got++;
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        iFull     = v.full;
        iReqValid = v.valid;
        iReqQoS   = v.qos;
        keepMask  = '0;
        for (int i = 0; i < NREQ; i++) begin
            iReqData[i*DSIZE +: DSIZE] = dataFor(i, 'h55);
        end
        doReset();
    endtask

    initial begin
        int got;
        int cyc;
        bit found;

        vecs[0]  = '{4'b0001, 16'h0000, 1'b0, 4'b0001, 1'b1, 2'd0, 4'h0, 1'b0};
        vecs[1]  = '{4'b1111, 16'h2222, 1'b0, 4'b0001, 1'b1, 2'd0, 4'h2, 1'b0};
        vecs[2]  = '{4'b1010, 16'h5030, 1'b0, 4'b1000, 1'b1, 2'd3, 4'h5, 1'b0};
        vecs[3]  = '{4'b0110, 16'h0780, 1'b0, 4'b0010, 1'b1, 2'd1, 4'h8, 1'b0};
        vecs[4]  = '{4'b1100, 16'hC900, 1'b0, 4'b1000, 1'b1, 2'd3, 4'hC, 1'b0};
        vecs[5]  = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 2'd0, 4'h0, 1'b0};
        vecs[6]  = '{4'b1110, 16'h3330, 1'b0, 4'b0010, 1'b1, 2'd1, 4'h3, 1'b0};
        vecs[7]  = '{4'b1111, 16'h1234, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0, 1'b0};
        vecs[8]  = '{4'b0101, 16'h0F0F, 1'b0, 4'b0001, 1'b1, 2'd0, 4'hF, 1'b0};
        vecs[9]  = '{4'b0100, 16'h000F, 1'b0, 4'b0100, 1'b1, 2'd2, 4'h0, 1'b0};
        vecs[10] = '{4'b1001, 16'hF007, 1'b0, 4'b1000, 1'b1, 2'd3, 4'hF, 1'b0};

        // Power-on reset state
        iWrResetn = 1'b1;
        #1;
        iWrResetn = 1'b0;
        #2;
        checkOutput("reset oWr", oWr, 0);
        checkOutput("reset oWrData", oWrData, 0);
        checkOutput("reset oQoS", oQoS, 0);
        checkOutput("reset oGrantId", oGrantId, 0);
        checkOutput("reset oAged", oAged, 0);
        checkOutput("reset oReqReady", oReqReady, 0);
        @(posedge iWrClk);
        #1;
        iWrResetn = 1'b1;

        // Vector table: one accept decision from a fresh reset each time
        for (int n = 0; n < NVEC; n++) begin
            applyStimulus(vecs[n]);
            @(negedge iWrClk);
            checkOutput($sformatf("vec%0d ready", n), oReqReady, vecs[n].expReady);
            @(posedge iWrClk);
            #1;
            checkOutput($sformatf("vec%0d oWr", n), oWr, vecs[n].expWr);
            if (vecs[n].expWr) begin
                checkOutput($sformatf("vec%0d id", n), oGrantId, vecs[n].expId);
                checkOutput($sformatf("vec%0d qos", n), oQoS, vecs[n].expQos);
                checkOutput($sformatf("vec%0d aged", n), oAged, vecs[n].expAged);
                checkOutput($sformatf("vec%0d data", n), oWrData,
                            dataFor(int'(vecs[n].expId), 'h55));
            end
            iReqValid = '0;
            iFull     = 1'b0;
        end

        // Reset while a word is on the write port
        doReset();
        keepMask = '0;
        setReq(2, 4'h3, dataFor(2, 1));
        tick();
        checkOutput("T1 pre oWr", oWr, 1);
        checkOutput("T1 pre id", oGrantId, 2);
        iReqValid = 4'b1111;
        iReqQoS   = 16'h2222;
        iWrResetn = 1'b0;
        #1;
        checkOutput("T1 oWr", oWr, 0);
        checkOutput("T1 oWrData", oWrData, 0);
        checkOutput("T1 oQoS", oQoS, 0);
        checkOutput("T1 oGrantId", oGrantId, 0);
        checkOutput("T1 oAged", oAged, 0);
        checkOutput("T1 oReqReady", oReqReady, 0);
        iReqValid = '0;
        tick();
        iWrResetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("T1 no spurious oWr %0d", k), oWr, 0);
        end
        iReqValid = 4'b1111;
        @(negedge iWrClk);
        checkOutput("T1 rr pointer cleared", oReqReady, 4'b0001);
        iReqValid = '0;
        @(posedge iWrClk);
        #1;

        // QoS ordering with the one-cycle gap
        doReset();
        keepMask = '0;
        setReq(0, 4'd1, dataFor(0, 2));
        setReq(1, 4'd5, dataFor(1, 2));
        setReq(2, 4'd9, dataFor(2, 2));
        collectIssues(3, 20, got);
        checkOutput("T2 count", got, 3);
        checkOutput("T2 id0", issId[0], 2);
        checkOutput("T2 id1", issId[1], 1);
        checkOutput("T2 id2", issId[2], 0);
        checkOutput("T2 qos0", issQos[0], 9);
        checkOutput("T2 qos1", issQos[1], 5);
        checkOutput("T2 qos2", issQos[2], 1);
        checkOutput("T2 data0", issData[0], dataFor(2, 2));
        checkOutput("T2 data2", issData[2], dataFor(0, 2));
        checkOutput("T2 spacing a", issCyc[1] - issCyc[0], 2);
        checkOutput("T2 spacing b", issCyc[2] - issCyc[1], 2);

        // Round-robin among equal QoS, continuous requests
        doReset();
        keepMask = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            setReq(i, 4'd2, dataFor(i, 3));
        end
        collectIssues(8, 40, got);
        checkOutput("T3 count", got, 8);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("T3 id%0d", k), issId[k], k % NREQ);
        end
        iReqValid = '0;
        keepMask  = '0;
        tick();

        // Aging: low-QoS requestor starved by a higher one
        doReset();
        keepMask = 4'b1001;
        setReq(0, 4'd4, dataFor(0, 4));
        setReq(3, 4'd0, dataFor(3, 4));
        found = 1'b0;
        cyc   = 0;
        for (int c = 1; c <= 30 && !found; c++) begin
            tick();
            cyc = c;
            if (oWr === 1'b1) begin
                if (oGrantId == 2'd3) begin
                    found = 1'b1;
                end else begin
                    checkOutput("T4 req0 qos", oQoS, 4);
                end
            end
        end
        checkOutput("T4 req3 issued", found, 1);
        checkOutput("T4 within bound", cyc <= AGE_LIMIT + ISSUE_GAP + 2, 1);
        checkOutput("T4 qos", oQoS, 4'b0110);
        checkOutput("T4 aged", oAged, 1);
        checkOutput("T4 data", oWrData, dataFor(3, 4));
        iReqValid = '0;
        keepMask  = '0;
        tick();

        // Full blocks accepts; pending words survive
        doReset();
        keepMask = '0;
        iFull    = 1'b1;
        setReq(0, 4'd2, dataFor(0, 5));
        setReq(1, 4'd2, dataFor(1, 5));
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput($sformatf("T5 ready held %0d", k), readyCap, 0);
            checkOutput($sformatf("T5 oWr held %0d", k), oWr, 0);
        end
        iFull = 1'b0;
        collectIssues(2, 8, got);
        checkOutput("T5 count", got, 2);
        checkOutput("T5 first latency", issCyc[0] <= 2, 1);
        checkOutput("T5 id0", issId[0], 0);
        checkOutput("T5 id1", issId[1], 1);
        checkOutput("T5 data0", issData[0], dataFor(0, 5));
        checkOutput("T5 data1", issData[1], dataFor(1, 5));

        // HiBW beats an aged requestor; aged one follows promoted
        doReset();
        keepMask = '0;
        iFull    = 1'b1;
        setReq(1, 4'd3, dataFor(1, 6));
        for (int k = 0; k < 14; k++) begin
            tick();
        end
        checkOutput("T6 ready while full", readyCap, 0);
        setReq(2, 4'd8, dataFor(2, 6));
        iFull = 1'b0;
        collectIssues(2, 8, got);
        checkOutput("T6 count", got, 2);
        checkOutput("T6 id0", issId[0], 2);
        checkOutput("T6 qos0", issQos[0], 8);
        checkOutput("T6 aged0", issAged[0], 0);
        checkOutput("T6 id1", issId[1], 1);
        checkOutput("T6 qos1", issQos[1], 6);
        checkOutput("T6 aged1", issAged[1], 1);
        checkOutput("T6 data1", issData[1], dataFor(1, 6));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
